// File: rtl/avalon_spi_pkg.sv
// Shared definitions for the Avalon-MM SPI CSR slave: register map,
// STATUS bit layout and the bus / transfer FSM state encodings.
package avalon_spi_pkg;

    // Register word addresses
    localparam int unsigned REG_TXDATA   = 0;
    localparam int unsigned REG_RXDATA   = 1;
    localparam int unsigned REG_STATUS   = 2;
    localparam int unsigned REG_CONTROL  = 3;
    localparam int unsigned REG_IRQ_EN   = 4;
    localparam int unsigned REG_CMD_READ = 5;

    // STATUS bit indices
    localparam int unsigned ST_BUSY     = 0;
    localparam int unsigned ST_RX_VALID = 1;
    localparam int unsigned ST_OVERRUN  = 2;
    localparam int unsigned ST_TX_ERR   = 3;
    localparam int unsigned ST_DONE     = 4;

    // STATUS payload, LSB first in declaration order reversed (busy is bit 0)
    typedef struct packed {
        logic done;
        logic tx_err;
        logic overrun;
        logic rx_valid;
        logic busy;
    } status_t;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_GO   = 2'd1,
        T_WAIT = 2'd2
    } xfer_state_e;

endpackage

// File: rtl/spi_go_pulse_gen.sv
// Start pulse generator: a load raises pulse for exactly GO_LEN cycles.
// Ports: clk, reset_n, load (start request), pulse (registered spi_go),
//        last_c (combinational: pulse is in its final cycle).
module spi_go_pulse_gen #(
    parameter int unsigned GO_LEN = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic pulse,
    output logic last_c
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] cnt;

    // Counter holds the number of pulse cycles remaining after the current one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            pulse <= 1'b1;
            cnt   <= CNT_W'(GO_LEN - 1);
        end else if (pulse) begin
            if (cnt == '0) begin
                pulse <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign last_c = pulse & (cnt == '0);

endmodule

// File: rtl/avalon_spi_csr.sv
// Avalon-MM slave front end for the SPI shift engine.
// Ports: Avalon side (chip_select, address, write, write_data, read,
//        read_data, wait_request), SPI engine side (spi_tx_data, spi_go,
//        spi_cs_sel, spi_done, spi_rx_data) and a level interrupt irq.
// Every access takes two cycles: wait_request is high in BUS_IDLE while an
// access is presented, the access commits on that edge, BUS_ACK completes it.
module avalon_spi_csr
    import avalon_spi_pkg::*;
#(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        ADDR_W     = 3,
    parameter int unsigned        NUM_CS     = 4,
    parameter int unsigned        GO_LEN     = 7,
    parameter logic [DATA_W-1:0]  DUMMY_WORD = '1,
    localparam int unsigned       CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chip_select,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read,
    output logic [DATA_W-1:0] read_data,
    output logic              wait_request,
    output logic [DATA_W-1:0] spi_tx_data,
    output logic              spi_go,
    output logic [CS_W-1:0]   spi_cs_sel,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_rx_data,
    output logic              irq
);

    bus_state_e  bus_state, bus_next;
    xfer_state_e x_state, x_next;

    logic [CS_W-1:0]   ctrl_cs;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] rd_mux_c;
    logic              done_ie, rx_ie;
    logic              rx_valid, overrun, tx_err, done;
    logic              done_prev;
    logic              busy_c, go_load_c, go_last_c;
    status_t           status_c;

    // Access decode; an access commits only on the BUS_IDLE edge
    logic access_c, commit_c, wr_c, rd_c, rd_rx_c;
    logic is_tx_c, is_rx_c, is_st_c, is_ctl_c, is_ie_c, is_cmd_c;
    logic start_c, complete_c;

    assign access_c = chip_select & (read | write);
    assign commit_c = (bus_state == BUS_IDLE) & access_c;
    assign wr_c     = commit_c & write;
    assign rd_c     = commit_c & read;
    assign is_tx_c  = (address == ADDR_W'(REG_TXDATA));
    assign is_rx_c  = (address == ADDR_W'(REG_RXDATA));
    assign is_st_c  = (address == ADDR_W'(REG_STATUS));
    assign is_ctl_c = (address == ADDR_W'(REG_CONTROL));
    assign is_ie_c  = (address == ADDR_W'(REG_IRQ_EN));
    assign is_cmd_c = (address == ADDR_W'(REG_CMD_READ));
    // Write wins over read, so read side effects only apply to pure reads
    assign rd_rx_c    = rd_c & ~write & is_rx_c;
    assign start_c    = wr_c & (is_tx_c | is_cmd_c);
    assign complete_c = (x_state == T_WAIT) & spi_done & ~done_prev;

    // Bus FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus_state <= BUS_IDLE;
        else          bus_state <= bus_next;
    end

    // Bus FSM: next state
    always_comb begin
        bus_next = bus_state;
        case (bus_state)
            BUS_IDLE: if (access_c) bus_next = BUS_ACK;
            BUS_ACK:  bus_next = BUS_IDLE;
            default:  bus_next = BUS_IDLE;
        endcase
    end

    // Bus FSM: outputs
    always_comb begin
        wait_request = 1'b0;
        if (bus_state == BUS_IDLE && access_c) wait_request = 1'b1;
    end

    // Transfer FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) x_state <= T_IDLE;
        else          x_state <= x_next;
    end

    // Transfer FSM: next state
    always_comb begin
        x_next = x_state;
        case (x_state)
            T_IDLE:  if (start_c)    x_next = T_GO;
            T_GO:    if (go_last_c)  x_next = T_WAIT;
            T_WAIT:  if (complete_c) x_next = T_IDLE;
            default: x_next = T_IDLE;
        endcase
    end

    // Transfer FSM: outputs
    always_comb begin
        busy_c    = 1'b0;
        go_load_c = 1'b0;
        if (x_state != T_IDLE) busy_c = 1'b1;
        if (x_state == T_IDLE && start_c) go_load_c = 1'b1;
    end

    spi_go_pulse_gen #(.GO_LEN(GO_LEN)) u_go (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (go_load_c),
        .pulse   (spi_go),
        .last_c  (go_last_c)
    );

    // Read data source selection
    always_comb begin
        status_c.done     = done;
        status_c.tx_err   = tx_err;
        status_c.overrun  = overrun;
        status_c.rx_valid = rx_valid;
        status_c.busy     = busy_c;
        rd_mux_c = '0;
        if      (is_tx_c)  rd_mux_c = spi_tx_data;
        else if (is_rx_c)  rd_mux_c = rx_word;
        else if (is_st_c)  rd_mux_c = DATA_W'(status_c);
        else if (is_ctl_c) rd_mux_c = DATA_W'(ctrl_cs);
        else if (is_ie_c)  rd_mux_c = DATA_W'({rx_ie, done_ie});
    end

    // Register file, status flags and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data   <= '0;
            spi_tx_data <= '0;
            spi_cs_sel  <= '0;
            ctrl_cs     <= '0;
            rx_word     <= '0;
            done_ie     <= 1'b0;
            rx_ie       <= 1'b0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
            tx_err      <= 1'b0;
            done        <= 1'b0;
            done_prev   <= 1'b0;
            irq         <= 1'b0;
        end else begin
            done_prev <= spi_done;
            irq       <= (done_ie & done) | (rx_ie & rx_valid);

            if (rd_c) read_data <= rd_mux_c;

            if (go_load_c) begin
                spi_tx_data <= is_cmd_c ? DUMMY_WORD : write_data;
                spi_cs_sel  <= ctrl_cs;
            end

            if (wr_c && is_ctl_c) ctrl_cs <= (NUM_CS > 1) ? write_data[CS_W-1:0] : '0;
            if (wr_c && is_ie_c) begin
                done_ie <= write_data[0];
                rx_ie   <= write_data[1];
            end

            if (complete_c) rx_word <= spi_rx_data;

            // Set conditions take priority over clears on the same edge
            if (complete_c)   rx_valid <= 1'b1;
            else if (rd_rx_c) rx_valid <= 1'b0;

            if (complete_c && rx_valid && !rd_rx_c)           overrun <= 1'b1;
            else if (wr_c && is_st_c && write_data[ST_OVERRUN]) overrun <= 1'b0;

            if (start_c && busy_c)                             tx_err <= 1'b1;
            else if (wr_c && is_st_c && write_data[ST_TX_ERR]) tx_err <= 1'b0;

            if (complete_c)                                  done <= 1'b1;
            else if (wr_c && is_st_c && write_data[ST_DONE]) done <= 1'b0;
        end
    end

endmodule
